// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder backed by a 16-bit-wide RAM, oversampled on the system clock.
// Frames are rwb + 16-bit address + 16-bit data, MSB first; a parallel host port allows preload and inspection.
module spi_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk_i,
  input  logic              csb_i,
  input  logic              si_i,
  output logic              so_o,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [15:0]       host_wdata_i,
  output logic [15:0]       host_rdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              abort_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    ADDR     = 3'd2,
    WDATA    = 3'd3,
    RDATA    = 3'd4,
    WAIT_CSB = 3'd5
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, csb_sync, si_sync;
  logic sclk_s, csb_s, si_s, sclk_d;
  logic rise, fall;

  logic [3:0]        cnt;
  logic              rwb;
  logic [ADDR_W-1:0] addr_sr;
  logic [ADDR_W-1:0] addr_next;
  logic [14:0]       data_sr;
  logic [15:0]       data_next;
  logic [15:0]       tx_sr;
  logic              so_q, done_q, abort_q;
  logic              last_bit;
  logic              spi_we, load_tx, done_evt, abort_evt;

  logic [15:0] mem [0:(1<<ADDR_W)-1];

  // The MSB of each chain is the oldest, fully synchronized sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync <= '0;
      csb_sync  <= '1;
      si_sync   <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
      csb_sync  <= {csb_sync[SYNC_STAGES-2:0], csb_i};
      si_sync   <= {si_sync[SYNC_STAGES-2:0], si_i};
      sclk_d    <= sclk_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csb_s     = csb_sync[SYNC_STAGES-1];
  assign si_s      = si_sync[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_d;
  assign fall      = ~sclk_s & sclk_d;
  assign last_bit  = rise && (cnt == 4'd15);
  assign addr_next = {addr_sr[ADDR_W-2:0], si_s};
  assign data_next = {data_sr, si_s};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    spi_we     = 1'b0;
    load_tx    = 1'b0;
    done_evt   = 1'b0;
    abort_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (!csb_s) state_next = CMD;
      end
      CMD: begin
        if (csb_s) begin
          state_next = IDLE;
          abort_evt  = 1'b1;
        end else if (rise) begin
          state_next = ADDR;
        end
      end
      ADDR: begin
        if (csb_s) begin
          state_next = IDLE;
          abort_evt  = 1'b1;
        end else if (last_bit) begin
          state_next = rwb ? RDATA : WDATA;
          load_tx    = rwb;
        end
      end
      WDATA: begin
        if (csb_s) begin
          state_next = IDLE;
          abort_evt  = 1'b1;
        end else if (last_bit) begin
          state_next = WAIT_CSB;
          spi_we     = 1'b1;
          done_evt   = 1'b1;
        end
      end
      RDATA: begin
        if (csb_s) begin
          state_next = IDLE;
          abort_evt  = 1'b1;
        end else if (last_bit) begin
          state_next = WAIT_CSB;
          done_evt   = 1'b1;
        end
      end
      WAIT_CSB: begin
        if (csb_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state != IDLE);
    so_o    = (state == RDATA) ? so_q : 1'b0;
    done_o  = done_q;
    abort_o = abort_q;
  end

  // The bit counter restarts on every state change so each field counts its own 16 rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      rwb     <= 1'b0;
      addr_sr <= '0;
      data_sr <= '0;
      tx_sr   <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q  <= done_evt;
      abort_q <= abort_evt;
      if (state_next != state) cnt <= '0;
      else if (rise)           cnt <= cnt + 4'd1;
      if (state == CMD && rise)   rwb     <= si_s;
      if (state == ADDR && rise)  addr_sr <= addr_next;
      if (state == WDATA && rise) data_sr <= data_next[14:0];
      if (load_tx) begin
        tx_sr <= mem[addr_next];
        so_q  <= 1'b0;
      end else if (state == RDATA && fall) begin
        so_q  <= tx_sr[15];
        tx_sr <= {tx_sr[14:0], 1'b0};
      end
    end
  end

  // The SPI write is issued last so it overrides a host write to the same word.
  always_ff @(posedge clk) begin
    if (host_we_i) mem[host_addr_i] <= host_wdata_i;
    if (spi_we)    mem[addr_sr]     <= data_next;
  end

  always_ff @(posedge clk) begin
    if (reset) host_rdata_o <= '0;
    else       host_rdata_o <= mem[host_addr_i];
  end

endmodule

// File: tb/tb_spi_mem_responder.sv
// Directed bench for spi_mem_responder: a bit-banged mode-0 master plus host-port
// accesses, with hand-computed expected words and pulse counts.
module tb_spi_mem_responder;

  localparam int ADDR_W = 8;
  localparam int HALF   = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              sclk, csb, si;
  logic              so;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [15:0]       host_wdata;
  logic [15:0]       host_rdata;
  logic              busy, done, abort;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  int abort_cnt = 0;

  spi_mem_responder #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .sclk_i       (sclk),
    .csb_i        (csb),
    .si_i         (si),
    .so_o         (so),
    .host_we_i    (host_we),
    .host_addr_i  (host_addr),
    .host_wdata_i (host_wdata),
    .host_rdata_o (host_rdata),
    .busy_o       (busy),
    .done_o       (done),
    .abort_o      (abort)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (done)  done_cnt  <= done_cnt + 1;
    if (abort) abort_cnt <= abort_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [15:0] d);
    host_addr  = a;
    host_wdata = d;
    host_we    = 1'b1;
    wait_clk(1);
    host_we    = 1'b0;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a, output logic [15:0] d);
    host_addr = a;
    wait_clk(1);
    d = host_rdata;
  endtask

  // Drives nrises sclk rising edges of {rwb, addr, data}, then releases csb.
  // With collide set, a one-cycle host write lands on the clk that commits the SPI write.
  task automatic spi_frame(input logic rwb, input logic [15:0] addr, input logic [15:0] data,
                           input int nrises, input logic collide,
                           input logic [ADDR_W-1:0] c_addr, input logic [15:0] c_data,
                           output logic [15:0] rdata);
    logic [32:0] frame;
    frame = {rwb, addr, data};
    rdata = '0;
    csb   = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nrises; i++) begin
      si = frame[32-i];
      wait_clk(HALF);
      sclk = 1'b1;
      if (i >= 17) rdata = {rdata[14:0], so};
      if (collide && i == 32) begin
        wait_clk(2);
        host_addr  = c_addr;
        host_wdata = c_data;
        host_we    = 1'b1;
        wait_clk(1);
        host_we    = 1'b0;
        wait_clk(HALF - 3);
      end else begin
        wait_clk(HALF);
      end
      sclk = 1'b0;
    end
    wait_clk(HALF);
    csb = 1'b1;
    si  = 1'b0;
    wait_clk(8);
  endtask

  logic [15:0] rd;
  int d0, a0;

  initial begin
    reset = 1'b1; sclk = 1'b0; csb = 1'b1; si = 1'b0;
    host_we = 1'b0; host_addr = '0; host_wdata = '0;
    wait_clk(4);
    check("rst_so", {15'd0, so}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    check("rst_abort", {15'd0, abort}, 16'd0);
    check("rst_host_rdata", host_rdata, 16'h0000);
    reset = 1'b0;
    wait_clk(2);

    // Write then read back over SPI
    d0 = done_cnt; a0 = abort_cnt;
    spi_frame(1'b0, 16'h0012, 16'hBEEF, 33, 1'b0, '0, '0, rd);
    check("wr_done_once", 16'(done_cnt - d0), 16'd1);
    spi_frame(1'b1, 16'h0012, 16'h0000, 33, 1'b0, '0, '0, rd);
    check("rd_beef", rd, 16'hBEEF);
    check("rd_done_total", 16'(done_cnt - d0), 16'd2);
    check("wr_rd_no_abort", 16'(abort_cnt - a0), 16'd0);
    check("so_idle_zero", {15'd0, so}, 16'd0);
    check("busy_after_frames", {15'd0, busy}, 16'd0);
    host_read(8'h12, rd);
    check("host_rd_12", rd, 16'hBEEF);

    // Host preload then SPI read
    host_write(8'h05, 16'hA5C3);
    host_addr = 8'h00;
    wait_clk(1);
    host_addr = 8'h05;
    wait_clk(1);
    check("host_rd_05_latency", host_rdata, 16'hA5C3);
    spi_frame(1'b1, 16'h0005, 16'h0000, 33, 1'b0, '0, '0, rd);
    check("spi_rd_a5c3", rd, 16'hA5C3);

    // Upper address bits wrap onto the RAM index
    spi_frame(1'b0, 16'h1234, 16'h1111, 33, 1'b0, '0, '0, rd);
    host_read(8'h34, rd);
    check("wrap_34", rd, 16'h1111);

    // Abort after 10 of 16 write-data bits
    host_write(8'h20, 16'h7777);
    d0 = done_cnt; a0 = abort_cnt;
    spi_frame(1'b0, 16'h0020, 16'hFFFF, 27, 1'b0, '0, '0, rd);
    check("abort_once", 16'(abort_cnt - a0), 16'd1);
    check("abort_no_done", 16'(done_cnt - d0), 16'd0);
    check("abort_busy", {15'd0, busy}, 16'd0);
    host_read(8'h20, rd);
    check("abort_mem_kept", rd, 16'h7777);

    // Same-cycle writes: same index, then different indices
    spi_frame(1'b0, 16'h0040, 16'h0001, 33, 1'b1, 8'h40, 16'h0002, rd);
    host_read(8'h40, rd);
    check("collide_same_idx", rd, 16'h0001);
    spi_frame(1'b0, 16'h0050, 16'h0003, 33, 1'b1, 8'h51, 16'h0004, rd);
    host_read(8'h50, rd);
    check("collide_spi_50", rd, 16'h0003);
    host_read(8'h51, rd);
    check("collide_host_51", rd, 16'h0004);

    // Reset during the address phase of a write frame
    host_write(8'h03, 16'h3C3C);
    d0 = done_cnt; a0 = abort_cnt;
    csb = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < 9; i++) begin
      si = (i == 0) ? 1'b0 : 1'b1;
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    reset = 1'b1;
    wait_clk(2);
    csb = 1'b1;
    si  = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    check("rst_mid_busy", {15'd0, busy}, 16'd0);
    spi_frame(1'b1, 16'h0003, 16'h0000, 33, 1'b0, '0, '0, rd);
    check("rst_mid_read", rd, 16'h3C3C);
    check("rst_mid_no_abort", 16'(abort_cnt - a0), 16'd0);
    check("rst_mid_done", 16'(done_cnt - d0), 16'd1);
    host_read(8'h03, rd);
    check("rst_mid_mem_kept", rd, 16'h3C3C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_mem_responder.md
Name: spi_mem_responder

Overview:
- SPI responder (slave) that models the external instruction/data memory driven by the CPU's SPI master.
- Decodes frames of rwb bit + 16-bit address + 16-bit data and serves reads and writes against an internal 16-bit-wide RAM.
- Fully synchronous to the system clock: the SPI pins are oversampled, not used as clocks.
- Also exposes a parallel host port for preload and inspection by the bench or boot logic.

Parameters:
- ADDR_W, 8, internal RAM address bits (2^ADDR_W words of 16 bits).
- SYNC_STAGES, 2, synchronizer depth on sclk_i, csb_i and si_i (minimum 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous reset, active-high
- sclk_i  input  1  SPI clock from master; idle low (mode 0)
- csb_i  input  1  SPI chip select, active-low
- si_i  input  1  master-to-responder serial data
- so_o  output  1  responder-to-master serial data
- host_we_i  input  1  host write strobe
- host_addr_i  input  ADDR_W  host address
- host_wdata_i  input  16  host write data
- host_rdata_o  output  16  registered host read data, 1-cycle latency
- busy_o  output  1  high whenever state is not IDLE
- done_o  output  1  1-cycle pulse when a complete frame finishes
- abort_o  output  1  1-cycle pulse when csb rises mid-frame

Behaviour:
- Clocking constraint: clk frequency must be at least 8x sclk frequency.
- Input conditioning:
  - sclk, csb and si each pass through SYNC_STAGES flops.
  - Rising and falling sclk edges are detected from the last two synchronized samples.
- Frame format (mode 0):
  - Master samples on the sclk rising edge and shifts on the falling edge; all fields are MSB first.
  - Bit 0 is rwb (1 = read), then 16 address bits, then 16 data bits: 33 rising edges in total.
  - RAM index is address[ADDR_W-1:0]; upper address bits are ignored (wrap-around).
- FSM states: IDLE, CMD, ADDR, WDATA, RDATA, WAIT_CSB.
  - IDLE: synchronized csb low -> CMD, bit counter cleared.
  - CMD: on sclk rise, latch rwb = si -> ADDR.
  - ADDR: shift si in on each rise. On the 16th rise:
    - if rwb: load mem[index] into the TX shift register -> RDATA.
    - else -> WDATA.
  - RDATA:
    - On each sclk fall, drive the next TX bit onto so_o; the first fall after entry drives bit 15.
    - On the 16th rise, pulse done_o -> WAIT_CSB.
  - WDATA: shift si in on each rise. On the 16th rise, write mem[index], pulse done_o -> WAIT_CSB.
  - WAIT_CSB: ignore sclk; synchronized csb high -> IDLE.
- csb high in CMD, ADDR, WDATA or RDATA:
  - FSM goes to IDLE on the next clk and abort_o pulses once.
  - An incomplete write is never committed; the RAM is unchanged.
- so_o is 0 outside RDATA. It holds its value between falling edges.
- Host port:
  - host_we_i writes mem[host_addr_i] at clk.
  - host_rdata_o <= mem[host_addr_i] every clk. Read-during-write returns the old data.
  - If an SPI write commit and a host write hit the same cycle, the SPI write wins at its own index. The host write still commits when the indices differ.
- Reset:
  - FSM -> IDLE; counters and shift registers cleared.
  - so_o = 0, busy_o = 0, done_o = 0, abort_o = 0, host_rdata_o = 0.
  - Synchronizer flops reset to 1 for csb and 0 for sclk and si.
  - RAM contents are not cleared.
  - Reset asserted mid-frame aborts silently: no abort_o pulse, no write.
- Back-to-back frames: a new frame is accepted once csb has been seen high for at least one synchronized sample, through WAIT_CSB -> IDLE.

Test Plan:
- Write then read:
  - SPI write addr 0x0012, data 0xBEEF, then SPI read addr 0x0012 -> so_o returns 0xBEEF MSB first.
  - done_o pulses once per frame; abort_o stays 0.
- Host preload: host write mem[0x05]=0xA5C3, then SPI read addr 0x0005 -> master samples 0xA5C3; host_rdata_o at 0x05 reads 0xA5C3 one cycle after the address is presented.
- Wrap-around: with ADDR_W=8, SPI write addr 0x1234, data 0x1111 -> host read 0x34 returns 0x1111.
- Abort: raise csb after 10 of 16 write-data bits to addr 0x0020 (prior content 0x7777) -> abort_o pulses once, mem[0x20] stays 0x7777, busy_o returns to 0.
- Write collision: an SPI write to 0x40 (0x0001) commits in the same clk as a host write to 0x40 (0x0002) -> mem[0x40] = 0x0001.
- Reset mid-frame: assert reset during ADDR, then run a clean read of addr 0x0003 -> correct data returned, no abort_o and no write observed.
